// File: rtl/ps2_rx_port_pkg.sv
`default_nettype none
// ============================================================================
// ps2_rx_port_pkg : shared port IDs, status bit map and FSM encoding
// Revision: 1.0
// ============================================================================
package ps2_rx_port_pkg;

  localparam logic [7:0] DEF_DATA_PORT   = 8'd3;
  localparam logic [7:0] DEF_STATUS_PORT = 8'd13;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_PARITY_ERR = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic odd_ones(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// ps2_rx_frame : PS/2 pin synchroniser, clock filter, deframing FSM, timeout
// Revision: 1.0
// ============================================================================
module ps2_rx_frame
  import ps2_rx_port_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       par_err,
  output logic       frm_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]          ps2c_sync_q, ps2c_sync_d, ps2d_sync_q, ps2d_sync_d;
  logic [FILT_LEN-1:0] filt_q, filt_d;
  logic                clkf_q, clkf_d;
  logic [1:0]          state_q, state_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                byte_ok_q, byte_ok_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                fall, din, par_good;

  assign din = ps2d_sync_q[1];

  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[0], ps2c};
    ps2d_sync_d = {ps2d_sync_q[0], ps2d};
    filt_d      = {filt_q[FILT_LEN-2:0], ps2c_sync_q[1]};
    clkf_d      = clkf_q;
    if (&filt_q)
      clkf_d = 1'b1;
    else if (~|filt_q)
      clkf_d = 1'b0;
  end

  assign fall = clkf_q & ~clkf_d;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_ok_d = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    par_good  = odd_ones(shift_q, parity_q);
    tmo_d     = (state_q == S_IDLE || fall) ? '0 : tmo_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (fall && !din) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7)
            state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_d = din;
          state_d  = S_STOP;
        end
      end
      default: begin
        if (fall) begin
          state_d   = S_IDLE;
          byte_ok_d = par_good & din;
          par_err_d = ~par_good;
          frm_err_d = ~din;
        end
      end
    endcase
    // A stalled frame is silently dropped so the next start bit resyncs.
    if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      filt_q      <= '1;
      clkf_q      <= 1'b1;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      byte_ok_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      filt_q      <= filt_d;
      clkf_q      <= clkf_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      byte_ok_q   <= byte_ok_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign rx_byte = shift_q;
  assign byte_ok = byte_ok_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_port.sv
`default_nettype none
// ============================================================================
// ps2_rx_port : PS/2 keyboard receiver with PicoBlaze input-port FIFO/status
// Revision: 1.0
// ============================================================================
module ps2_rx_port
  import ps2_rx_port_pkg::*;
#(
  parameter logic [7:0] PS2_DATA_PORT   = DEF_DATA_PORT,
  parameter logic [7:0] PS2_STATUS_PORT = DEF_STATUS_PORT,
  parameter int         FIFO_AW         = 2,
  parameter int         FILT_LEN        = 8,
  parameter int         TIMEOUT_CYC     = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] data_out,
  output logic       rx_ready
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]       rx_byte;
  logic             byte_ok, par_err, frm_err;
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             overrun_q, overrun_d, parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d, rx_ready_q, rx_ready_d;
  logic             empty, full, data_rd, status_rd, pop, push;
  logic [7:0]       status;

  ps2_rx_frame #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk     (clk),
    .reset   (reset),
    .ps2c    (ps2c),
    .ps2d    (ps2d),
    .rx_byte (rx_byte),
    .byte_ok (byte_ok),
    .par_err (par_err),
    .frm_err (frm_err)
  );

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]) && (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]);
  assign data_rd   = read_strobe && (port_id == PS2_DATA_PORT);
  assign status_rd = read_strobe && (port_id == PS2_STATUS_PORT);
  assign pop       = data_rd && !empty;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts.
  assign push      = byte_ok && (!full || pop);

  always_comb begin
    wptr_d       = wptr_q + {{FIFO_AW{1'b0}}, push};
    rptr_d       = rptr_q + {{FIFO_AW{1'b0}}, pop};
    overrun_d    = (byte_ok && full && !pop) || (overrun_q && !status_rd);
    parity_err_d = par_err || (parity_err_q && !status_rd);
    frame_err_d  = frm_err || (frame_err_q && !status_rd);
    rx_ready_d   = (wptr_d != rptr_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_ready_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_ready_q   <= rx_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q[FIFO_AW-1:0]] <= rx_byte;
  end

  always_comb begin
    status                = 8'h00;
    status[ST_NOT_EMPTY]  = !empty;
    status[ST_FULL]       = full;
    status[ST_OVERRUN]    = overrun_q;
    status[ST_PARITY_ERR] = parity_err_q;
    status[ST_FRAME_ERR]  = frame_err_q;
    data_out              = 8'h00;
    if (port_id == PS2_DATA_PORT)
      data_out = empty ? 8'h00 : mem_q[rptr_q[FIFO_AW-1:0]];
    else if (port_id == PS2_STATUS_PORT)
      data_out = status;
  end

  assign rx_ready = rx_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_port.sv
`default_nettype none
// ============================================================================
// tb_ps2_rx_port : directed PS/2 frames against a byte-queue/flag model
// Revision: 1.0
// ============================================================================
module tb_ps2_rx_port;

  // Bit timing and timeout are scaled down so every frame fits a short run.
  localparam int H   = 20;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, read_strobe, rx_ready;
  logic [7:0] port_id, data_out;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic       m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
  logic [7:0] v;

  always #5 clk = ~clk;

  ps2_rx_port #(
    .PS2_DATA_PORT   (8'd3),
    .PS2_STATUS_PORT (8'd13),
    .FIFO_AW         (2),
    .FILT_LEN        (8),
    .TIMEOUT_CYC     (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .port_id     (port_id),
    .read_strobe (read_strobe),
    .data_out    (data_out),
    .rx_ready    (rx_ready)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      cyc(H / 2);
      ps2c = 1'b0;
      cyc(H);
      ps2c = 1'b1;
      cyc(H / 2);
    end
    ps2d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_ok);
    logic p;
    p = ~^d;
    if (!par_ok) p = ~p;
    send_bits({stop_ok, p, d, 1'b0}, 11);
    cyc(10);
    if (!par_ok) m_perr = 1'b1;
    if (!stop_ok) m_ferr = 1'b1;
    if (par_ok && stop_ok) begin
      if (exp_q.size() == 4) m_ovr = 1'b1;
      else exp_q.push_back(d);
    end
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] val);
    @(negedge clk);
    port_id     = id;
    read_strobe = 1'b1;
    #1 val = data_out;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] exp, got;
    exp = {3'b000, m_ferr, m_perr, m_ovr, exp_q.size() == 4, exp_q.size() != 0};
    read_port(8'd13, got);
    check8(tag, got, exp);
    m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic check_data(input string tag);
    logic [7:0] exp, got;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    read_port(8'd3, got);
    check8(tag, got, exp);
  endtask

  task automatic check_rdy(input string tag);
    check8(tag, {7'b0, rx_ready}, {7'b0, exp_q.size() != 0});
  endtask

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; read_strobe = 1'b0; port_id = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    check_rdy("reset_rdy");
    check_status("reset_status");
    check_data("reset_empty_read");
    read_port(8'h05, v);
    check8("other_port", v, 8'h00);

    send_frame(8'h1C, 1'b1, 1'b1);
    check_rdy("good_rdy_high");
    check_status("good_status");
    check_data("good_data");
    check_status("good_status_after");
    check_rdy("good_rdy_low");

    send_frame(8'h1C, 1'b0, 1'b1);
    check_status("parity_err_status");
    check_status("parity_err_cleared");
    check_rdy("parity_err_no_push");

    send_frame(8'h1C, 1'b1, 1'b0);
    check_status("frame_err_status");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_status("both_err_status");

    for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b1);
    check_status("overrun_status");
    for (int i = 0; i < 5; i++) check_data("fifo_drain");
    check_status("drain_status");

    send_bits(11'b000_0000_1010, 4);
    cyc(TMO + 200);
    send_frame(8'h55, 1'b1, 1'b1);
    check_status("timeout_status");
    check_data("timeout_data");

    ps2c = 1'b0;
    cyc(3);
    ps2c = 1'b1;
    cyc(20);
    send_frame(8'hF0, 1'b1, 1'b1);
    check_data("glitch_data");
    check_status("glitch_status");

    send_frame(8'h33, 1'b1, 1'b1);
    check_rdy("pre_reset_rdy");
    send_bits({2'b11, 8'h6A, 1'b0}, 6);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    exp_q.delete();
    m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    cyc(2);
    check_status("mid_reset_status");
    check_rdy("mid_reset_rdy");
    send_frame(8'h29, 1'b1, 1'b1);
    check_data("post_reset_data");
    check_status("post_reset_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx_port.md
Name: ps2_rx_port

Overview:
PS/2 keyboard receiver with a PicoBlaze input-port interface. Its output feeds the processor's `in_port` mux at the ps2_data and ps2_status port IDs, replacing the constant `teclado` register in the top level. It synchronises and filters the PS/2 clock, deframes 11-bit device-to-host frames, checks odd parity and the stop bit, and buffers good scan codes in a small FIFO. The processor polls status and pops bytes with `read_strobe`.

Parameters:
- PS2_DATA_PORT, 3, port_id that returns the FIFO head byte and pops it on `read_strobe`.
- PS2_STATUS_PORT, 13, port_id that returns the status byte; reading it clears the sticky error flags.
- FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW (default 4).
- FILT_LEN, 8, consecutive equal samples required before the filtered ps2c changes level.
- TIMEOUT_CYC, 20000, clk cycles without a filtered falling edge before an in-progress frame is aborted (200 us at 100 MHz).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- ps2c, input, 1, PS/2 clock from the pin; asynchronous.
- ps2d, input, 1, PS/2 data from the pin; asynchronous.
- port_id, input, 8, PicoBlaze port_id.
- read_strobe, input, 1, PicoBlaze read_strobe.
- data_out, output, 8, combinational value for the top-level `in_port` mux.
- rx_ready, output, 1, registered; high while the FIFO is not empty (usable as an interrupt source).

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; FIFO is emptied; all flags are 0; rx_ready = 0.
  - Filter registers are set to 1 (bus idle); timeout counter is 0.
  - Reset asserted mid-frame discards the partial frame.
- Synchronisation:
  - ps2c and ps2d each pass through a 2-FF synchroniser.
  - The filter shifts synced ps2c into a FILT_LEN-bit register.
  - Filtered clock goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds its level.
  - fall = one-cycle pulse on a filtered 1->0 transition. Synced ps2d is sampled in the fall cycle.
- FSM:
  - IDLE: fall with d=0 -> DATA, bitcnt=0. fall with d=1 -> stay in IDLE (spurious edge).
  - DATA: each fall shifts d into the shift register LSB-first. After the 8th bit -> PARITY.
  - PARITY: fall captures the parity bit -> STOP.
  - STOP: fall captures the stop bit and evaluates the frame -> IDLE.
  - The frame is good if ones(data) + parity is odd and stop = 1.
    - Parity bad: set parity_err and discard the byte.
    - Stop = 0 (parity good): set frame_err and discard the byte.
    - If both are bad, set both flags.
- Timeout:
  - Counter clears on every fall and while in IDLE.
  - In any other state, when the count reaches TIMEOUT_CYC the FSM returns to IDLE and discards the partial frame. No flag is set.
- FIFO push:
  - A good frame pushes in the cycle after the stop-bit fall.
  - data_out and rx_ready reflect the new byte one cycle after that.
  - Push when full: byte dropped, overrun set.
  - Exception: a push and a pop in the same cycle while full is accepted and does not set overrun.
- data_out (combinational):
  - port_id == PS2_DATA_PORT: FIFO head, or 8'h00 when empty.
  - port_id == PS2_STATUS_PORT: {3'b0, frame_err, parity_err, overrun, full, not_empty}.
  - Any other port_id: 8'h00.
- Pop:
  - read_strobe with port_id == PS2_DATA_PORT and FIFO not empty pops at that clock edge.
  - The processor samples the pre-pop head.
  - A read while empty returns 00 and changes no state.
- Status clear:
  - read_strobe with port_id == PS2_STATUS_PORT clears overrun, parity_err and frame_err at that edge.
  - An error event in the same cycle wins: the flag stays 1.
- Pointers are FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1).
  - full = address bits equal and MSBs differ.
  - empty = pointers equal.

Decomposition:
- Shared package:
  - Default port IDs (3, 13).
  - Status bit indices: NOT_EMPTY=0, FULL=1, OVERRUN=2, PARITY_ERR=3, FRAME_ERR=4.
  - FSM state encoding: IDLE, DATA, PARITY, STOP.
- Sub-module ps2_rx_frame: synchroniser, filter, FSM and timeout. Outputs byte[7:0], byte_ok pulse, par_err pulse, frm_err pulse.
- The parent holds the FIFO, flags and port decode.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 80 us bit period:
  - Status reads 0x01; data read returns 0x1C; status then reads 0x00; rx_ready falls.
- Frame 0x1C with parity 1:
  - Nothing pushed; status reads 0x08.
  - A second status read returns 0x00.
- Five good frames 0x11..0x15 with no reads:
  - Status reads 0x07.
  - Four data reads return 0x11, 0x12, 0x13, 0x14; a fifth read returns 0x00.
  - The status read after the five data reads returns 0x00, because the first status read cleared overrun.
- Start bit plus 3 data bits, ps2c held high 300 us, then a full frame 0x55:
  - Only 0x55 is received; no error flags.
- 3-cycle low glitch on ps2c while idle, then frame 0xF0:
  - Glitch ignored; 0xF0 is received intact.
- Reset asserted after the 5th data bit, with one byte already in the FIFO:
  - Status reads 0x00 immediately; the next full frame 0x29 is received correctly.
